// File: rtl/avalon_multi_timer_pkg.sv
// Shared definitions for avalon_multi_timer: register offsets, bit indices, write strobes.
// Build option TIMER_PRESCALER_EN enables the per-channel prescaler.
package avalon_multi_timer_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    REG_STATUS   = 3'd0,
    REG_CONTROL  = 3'd1,
    REG_PERIOD   = 3'd2,
    REG_SNAP     = 3'd3,
    REG_PRESCALE = 3'd4,
    REG_PENDING  = 3'd5,
    REG_RSVD6    = 3'd6,
    REG_RSVD7    = 3'd7
  } reg_e;

  localparam int unsigned CTRL_ITO   = 0;
  localparam int unsigned CTRL_CONT  = 1;
  localparam int unsigned CTRL_START = 2;
  localparam int unsigned CTRL_STOP  = 3;

  localparam int unsigned ST_TO  = 0;
  localparam int unsigned ST_RUN = 1;

  // Per-channel decoded register write strobes
  typedef struct packed {
    logic status;
    logic control;
    logic period;
    logic snap;
    logic prescale;
  } wr_strb_t;

endpackage

// File: rtl/avalon_multi_timer_if.sv
// Avalon-MM slave bus bundle for avalon_multi_timer.
interface avalon_multi_timer_if #(
  parameter int unsigned AW = 5
);
  import avalon_multi_timer_pkg::*;

  logic [AW-1:0]     address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/avalon_multi_timer_channel.sv
// One down-counting timer channel: counter, RUN/TO control, channel registers.
// Prescaler present only when TIMER_PRESCALER_EN is defined.
module timer_channel
  import avalon_multi_timer_pkg::*;
#(
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned PRE_W        = 16,
  parameter int unsigned RESET_PERIOD = 19999
) (
  input  logic              clk,
  input  logic              reset,
  input  wr_strb_t          wr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [1:0]        status_o,
  output logic [1:0]        ctrl_o,
  output logic [CNT_W-1:0]  period_o,
  output logic [CNT_W-1:0]  snap_o,
  output logic [PRE_W-1:0]  pre_o,
  output logic              irq_o
);

  logic [1:0]       ctrl_q, ctrl_d;
  logic             run_q, run_d, to_q, to_d;
  logic             zero_q, zero_d, force_q, force_d;
  logic [CNT_W-1:0] period_q, period_d, cnt_q, cnt_d, snap_q, snap_d;
  logic             tick_c, cnt_zero_c, event_c, start_c, stop_c;

`ifdef TIMER_PRESCALER_EN
  logic [PRE_W-1:0] pre_q, pre_d, pcnt_q, pcnt_d;

  // Prescaler: tick on terminal count, restart on PRESCALE/PERIOD writes
  always_comb begin
    pre_d  = pre_q;
    tick_c = (pcnt_q == pre_q);
    pcnt_d = tick_c ? '0 : pcnt_q + PRE_W'(1);
    if (wr_i.prescale) pre_d = wdata_i[PRE_W-1:0];
    if (wr_i.prescale || wr_i.period) pcnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q  <= '0;
      pcnt_q <= '0;
    end else begin
      pre_q  <= pre_d;
      pcnt_q <= pcnt_d;
    end
  end

  assign pre_o = pre_q;
`else
  logic unused_prescale;
  assign unused_prescale = wr_i.prescale;
  assign tick_c          = 1'b1;
  assign pre_o           = '0;
`endif

  always_comb begin
    ctrl_d     = ctrl_q;
    period_d   = period_q;
    snap_d     = snap_q;
    run_d      = run_q;
    to_d       = to_q;
    cnt_d      = cnt_q;
    force_d    = wr_i.period;
    cnt_zero_c = (cnt_q == '0);
    zero_d     = cnt_zero_c;
    event_c    = cnt_zero_c & ~zero_q;
    start_c    = wr_i.control & wdata_i[CTRL_START];
    stop_c     = wr_i.control & wdata_i[CTRL_STOP];

    if (wr_i.control) ctrl_d = {wdata_i[CTRL_CONT], wdata_i[CTRL_ITO]};
    if (wr_i.period)  period_d = wdata_i[CNT_W-1:0];
    if (wr_i.snap)    snap_d = cnt_q;

    // A one-shot parks at zero; only continuous mode reloads
    if (force_q) begin
      cnt_d = period_q;
    end else if (run_q && tick_c) begin
      if (!cnt_zero_c)              cnt_d = cnt_q - CNT_W'(1);
      else if (ctrl_q[CTRL_CONT])   cnt_d = period_q;
    end

    if (run_q && cnt_zero_c && !ctrl_q[CTRL_CONT]) run_d = 1'b0;
    if (force_q || stop_c) run_d = 1'b0;
    if (start_c)           run_d = 1'b1;

    // A timeout beats a simultaneous software clear
    if (event_c)          to_d = 1'b1;
    else if (wr_i.status) to_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q   <= '0;
      run_q    <= 1'b0;
      to_q     <= 1'b0;
      zero_q   <= (RESET_PERIOD == 0);
      force_q  <= 1'b0;
      period_q <= CNT_W'(RESET_PERIOD);
      cnt_q    <= CNT_W'(RESET_PERIOD);
      snap_q   <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      run_q    <= run_d;
      to_q     <= to_d;
      zero_q   <= zero_d;
      force_q  <= force_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      snap_q   <= snap_d;
    end
  end

  always_comb begin
    status_o         = '0;
    status_o[ST_TO]  = to_q;
    status_o[ST_RUN] = run_q;
  end

  assign ctrl_o   = ctrl_q;
  assign period_o = period_q;
  assign snap_o   = snap_q;
  assign irq_o    = to_q & ctrl_q[CTRL_ITO];

endmodule

// File: rtl/avalon_multi_timer.sv
// Multi-channel interval timer behind one Avalon-MM slave: decode, read mux, readdata register.
// Build option TIMER_PRESCALER_EN adds a prescaler to every channel.
module avalon_multi_timer
  import avalon_multi_timer_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned RESET_PERIOD = 19999,
  parameter int unsigned PRE_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  avalon_multi_timer_if.slave bus,
  output logic [NUM_CH-1:0]  irq,
  output logic               irq_any
);

  logic              wr_c;
  int unsigned       ch_c;
  reg_e              reg_c;
  wr_strb_t          wr_strb [NUM_CH];
  logic [1:0]        status_v [NUM_CH];
  logic [1:0]        ctrl_v   [NUM_CH];
  logic [CNT_W-1:0]  period_v [NUM_CH];
  logic [CNT_W-1:0]  snap_v   [NUM_CH];
  logic [PRE_W-1:0]  pre_v    [NUM_CH];
  logic [NUM_CH-1:0] to_v;
  logic [DATA_W-1:0] readdata_q, readdata_d;

  assign wr_c  = bus.chipselect & ~bus.write_n;
  assign ch_c  = 32'(bus.address) >> 3;
  assign reg_c = reg_e'(bus.address[2:0]);

  // Write strobes; channels past NUM_CH never match
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wr_strb[i] = '0;
      if (wr_c && ch_c == i) begin
        wr_strb[i].status   = (reg_c == REG_STATUS);
        wr_strb[i].control  = (reg_c == REG_CONTROL);
        wr_strb[i].period   = (reg_c == REG_PERIOD);
        wr_strb[i].snap     = (reg_c == REG_SNAP);
        wr_strb[i].prescale = (reg_c == REG_PRESCALE);
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    timer_channel #(
      .CNT_W        (CNT_W),
      .PRE_W        (PRE_W),
      .RESET_PERIOD (RESET_PERIOD)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .wr_i     (wr_strb[g]),
      .wdata_i  (bus.writedata),
      .status_o (status_v[g]),
      .ctrl_o   (ctrl_v[g]),
      .period_o (period_v[g]),
      .snap_o   (snap_v[g]),
      .pre_o    (pre_v[g]),
      .irq_o    (irq[g])
    );
    assign to_v[g] = status_v[g][ST_TO];
  end

  // Read mux follows address every cycle, independent of chipselect
  always_comb begin
    readdata_d = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_c == i) begin
        unique case (reg_c)
          REG_STATUS:   readdata_d = DATA_W'(status_v[i]);
          REG_CONTROL:  readdata_d = DATA_W'(ctrl_v[i]);
          REG_PERIOD:   readdata_d = DATA_W'(period_v[i]);
          REG_SNAP:     readdata_d = DATA_W'(snap_v[i]);
          REG_PRESCALE: readdata_d = DATA_W'(pre_v[i]);
          REG_PENDING:  readdata_d = DATA_W'(to_v);
          default:      readdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) readdata_q <= '0;
    else       readdata_q <= readdata_d;
  end

  assign bus.readdata = readdata_q;
  assign irq_any      = |irq;

endmodule

// File: tb/tb_avalon_multi_timer.sv
// Directed + randomized bench for avalon_multi_timer; timeout instants predicted arithmetically.
module tb_avalon_multi_timer;
  import avalon_multi_timer_pkg::*;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned AW     = $clog2(NUM_CH) + 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] irq;
  logic              irq_any;
  int unsigned       edge_n = 0;
  int unsigned       last_wr;
  int                n_cmp = 0;
  int                n_err = 0;

  avalon_multi_timer_if #(.AW(AW)) bus ();

  avalon_multi_timer #(.NUM_CH(NUM_CH)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .irq     (irq),
    .irq_any (irq_any)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_until(input int unsigned e);
    while (edge_n < e) idle(1);
  endtask

  task automatic wr(input int ch, input reg_e r, input logic [31:0] d);
    bus.address    = AW'((ch << 3) | int'(r));
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.writedata  = d;
    @(posedge clk); #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    last_wr        = edge_n;
  endtask

  task automatic rd(input int ch, input reg_e r, output logic [31:0] d);
    bus.address    = AW'((ch << 3) | int'(r));
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    @(posedge clk); #1;
    d              = bus.readdata;
    bus.chipselect = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    int unsigned es, p;
    logic        cont, sb;

    reset          = 1'b1;
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    idle(1);
    check("rst_readdata", bus.readdata, 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    idle(2);
    reset = 1'b0;
    check("rst_irq_any", 32'(irq_any), 32'd0);
    rd(0, REG_PERIOD, d);  check("rst_period", d, 32'd19999);
    rd(0, REG_STATUS, d);  check("rst_status", d, 32'd0);
    rd(1, REG_CONTROL, d); check("rst_control", d, 32'd0);
    rd(1, REG_SNAP, d);    check("rst_snap", d, 32'd0);

    // ch1 continuous, period 9: timeouts every 10 edges after START
    wr(1, REG_PERIOD, 32'd9);
    wr(1, REG_CONTROL, 32'h7);
    es = last_wr;
    wait_until(es + 9);
    check("c1_pre_to", 32'(irq[1]), 32'd0);
    idle(1);
    check("c1_to1", 32'(irq[1]), 32'd1);
    check("c1_irq_any", 32'(irq_any), 32'd1);
    rd(1, REG_STATUS, d);  check("c1_status", d, 32'h3);
    wr(1, REG_STATUS, 32'd0);
    check("c1_cleared", 32'(irq[1]), 32'd0);
    wait_until(es + 19);
    check("c1_still_clear", 32'(irq[1]), 32'd0);
    idle(1);
    check("c1_to2", 32'(irq[1]), 32'd1);
    wr(1, REG_STATUS, 32'd0);
    wait_until(es + 29);
    check("c1_pre_to3", 32'(irq[1]), 32'd0);
    wr(1, REG_STATUS, 32'd0);
    check("c1_clear_vs_event", 32'(irq[1]), 32'd1);
    rd(1, REG_CONTROL, d); check("c1_ctrl_stored", d, 32'h3);
    rd(0, REG_PENDING, d); check("pending_w0", d, 32'h2);
    rd(2, REG_PENDING, d); check("pending_w2", d, 32'h2);

    // PERIOD write while running stops the channel and loads the new value
    wr(1, REG_PERIOD, 32'd50);
    rd(1, REG_STATUS, d);  check("c1_run_before", d, 32'h3);
    rd(1, REG_STATUS, d);  check("c1_run_cleared", d, 32'h1);
    wr(1, REG_SNAP, 32'd0);
    rd(1, REG_SNAP, d);    check("c1_snap_newp", d, 32'd50);
    check("c1_irq_any_hold", 32'(irq_any), 32'd1);
    wr(1, REG_STATUS, 32'd0);
    check("irq_all_clear", 32'(irq), 32'd0);
    check("irq_any_clear", 32'(irq_any), 32'd0);

    // ch2 one-shot, period 4
    wr(2, REG_PERIOD, 32'd4);
    wr(2, REG_CONTROL, 32'h5);
    es = last_wr;
    wait_until(es + 4);
    check("c2_pre_to", 32'(irq[2]), 32'd0);
    idle(1);
    check("c2_to", 32'(irq[2]), 32'd1);
    rd(2, REG_STATUS, d);  check("c2_status_stop", d, 32'h1);
    wr(2, REG_STATUS, 32'd0);
    idle(15);
    check("c2_no_second_to", 32'(irq[2]), 32'd0);
    wr(2, REG_SNAP, 32'd0);
    rd(2, REG_SNAP, d);    check("c2_hold_zero", d, 32'd0);
    rd(2, REG_STATUS, d);  check("c2_status_idle", d, 32'd0);

    // Unmapped channel and reserved registers
    wr(3, REG_PERIOD, 32'h1234);
    rd(3, REG_PERIOD, d);  check("oor_period", d, 32'd0);
    rd(3, REG_STATUS, d);  check("oor_status", d, 32'd0);
    wr(0, REG_RSVD7, 32'hFFFF_FFFF);
    rd(0, REG_RSVD7, d);   check("rsvd7", d, 32'd0);
    rd(0, REG_RSVD6, d);   check("rsvd6", d, 32'd0);

    // Randomized periods/modes on ch0; first timeout at START + P + 1
    for (int it = 0; it < 6; it++) begin
      p    = $urandom_range(12, 4);
      cont = 1'($urandom_range(1, 0));
      sb   = 1'($urandom_range(1, 0));
      wr(0, REG_CONTROL, 32'h8);
      idle(2);
      wr(0, REG_STATUS, 32'd0);
      wr(0, REG_PERIOD, p);
      wr(0, REG_CONTROL, (32'(sb) << 3) | (32'(cont) << 1) | 32'h5);
      es = last_wr;
      wait_until(es + p);
      check("rnd_pre_to", 32'(irq[0]), 32'd0);
      idle(1);
      check("rnd_to", 32'(irq[0]), 32'd1);
      rd(0, REG_STATUS, d);  check("rnd_status", d, (32'(cont) << 1) | 32'h1);
      rd(0, REG_CONTROL, d); check("rnd_control", d, (32'(cont) << 1) | 32'h1);
      rd(0, REG_PERIOD, d);  check("rnd_period", d, p);
      if (cont) begin
        wr(0, REG_STATUS, 32'd0);
        wait_until(es + 2 * p + 1);
        check("rnd_gap", 32'(irq[0]), 32'd0);
        idle(1);
        check("rnd_to2", 32'(irq[0]), 32'd1);
      end
    end
    wr(0, REG_CONTROL, 32'h8);
    idle(2);
    wr(0, REG_STATUS, 32'd0);

`ifdef TIMER_PRESCALER_EN
    begin
      int unsigned e1, e2, budget;
      wr(0, REG_PRESCALE, 32'd3);
      rd(0, REG_PRESCALE, d); check("prescale_rb", d, 32'd3);
      wr(0, REG_PERIOD, 32'd2);
      wr(0, REG_CONTROL, 32'h7);
      budget = 0;
      while (irq[0] !== 1'b1 && budget < 40) begin idle(1); budget++; end
      e1 = edge_n;
      check("pre_first_to", 32'(irq[0]), 32'd1);
      wr(0, REG_STATUS, 32'd0);
      budget = 0;
      while (irq[0] !== 1'b1 && budget < 40) begin idle(1); budget++; end
      e2 = edge_n;
      check("pre_interval", e2 - e1, 32'd12);
    end
`else
    wr(0, REG_PRESCALE, 32'd3);
    rd(0, REG_PRESCALE, d); check("prescale_absent", d, 32'd0);
`endif

    // Reset mid-count returns everything to reset values
    wr(1, REG_PERIOD, 32'd3);
    wr(1, REG_CONTROL, 32'h7);
    es = last_wr;
    wait_until(es + 4);
    check("mid_to", 32'(irq[1]), 32'd1);
    reset = 1'b1;
    idle(1);
    check("mid_rst_irq", 32'(irq), 32'd0);
    check("mid_rst_any", 32'(irq_any), 32'd0);
    check("mid_rst_rd", bus.readdata, 32'd0);
    reset = 1'b0;
    rd(1, REG_PERIOD, d);  check("mid_rst_period", d, 32'd19999);
    rd(1, REG_STATUS, d);  check("mid_rst_status", d, 32'd0);
    idle(20);
    check("mid_rst_quiet", 32'(irq), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
